// File: rtl/testfunction2_types.sv
// Shared TestFunction2 types: the record bundle and the driver FSM state.
// Imported by the driver, its record generator and the port interface.
package testfunction2_types;

  typedef struct packed {
    logic signed [31:0] x;
    logic [31:0]        y;
  } record_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RECV,
    DONE
  } tf2_driver_state_t;

endpackage

// File: rtl/tf2_record_driver_if.sv
// Blocking-port bundle between the record driver and its consumer.
// Holds the b_in record offer and the b_out reply handshake.
interface tf2_record_driver_if
  import testfunction2_types::*;
  ;

  record_t     rec_out;
  logic        rec_out_notify;
  logic        rec_out_sync;
  logic [31:0] res_in;
  logic        res_in_notify;
  logic        res_in_sync;

  modport master (
    output rec_out,
    output rec_out_notify,
    input  rec_out_sync,
    input  res_in,
    output res_in_notify,
    input  res_in_sync
  );

  modport slave (
    input  rec_out,
    input  rec_out_notify,
    output rec_out_sync,
    output res_in,
    input  res_in_notify,
    output res_in_sync
  );

endinterface

// File: rtl/tf2_record_gen.sv
// Record generator: index and running x value for the current burst.
// Records come straight from registers, so they stay stable while offered.
module tf2_record_gen
  import testfunction2_types::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             adv,
  input  logic [31:0]      seed,
  input  logic [31:0]      stride,
  output logic [LEN_W-1:0] idx,
  output record_t          rec
);

  logic [LEN_W-1:0] idx_q, idx_d;
  logic [31:0]      x_q, x_d;
  logic [31:0]      stride_q, stride_d;

  always_comb begin
    idx_d    = idx_q;
    x_d      = x_q;
    stride_d = stride_q;
    if (load) begin
      idx_d    = '0;
      x_d      = seed;
      stride_d = stride;
    end else if (adv) begin
      idx_d = idx_q + LEN_W'(1);
      x_d   = x_q + stride_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      x_q      <= '0;
      stride_q <= '0;
    end else begin
      idx_q    <= idx_d;
      x_q      <= x_d;
      stride_q <= stride_d;
    end
  end

  assign idx = idx_q;
  assign rec = '{x: x_q, y: 32'(idx_q)};

endmodule

// File: rtl/tf2_record_driver.sv
// TestFunction2 initiator: sends a record burst, accumulates replies.
// Define TF2_DRIVER_TIMEOUT_EN to abort stalled bursts after TIMEOUT cycles.
module tf2_record_driver
  import testfunction2_types::*;
#(
  parameter int LEN_W   = 8,
  parameter int SUM_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic [31:0]          seed,
  input  logic [31:0]          stride,
  tf2_record_driver_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic [SUM_W-1:0]     sum,
  output logic                 err
);

  tf2_driver_state_t state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [LEN_W-1:0]  idx;
  record_t           rec;
  logic              load, adv;
  logic              rec_xfer, res_xfer, xfer;
  logic              timeout;

  tf2_record_gen #(.LEN_W(LEN_W)) u_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .adv    (adv),
    .seed   (seed),
    .stride (stride),
    .idx    (idx),
    .rec    (rec)
  );

  assign rec_xfer = (state_q == SEND) && bus.rec_out_sync;
  assign res_xfer = (state_q == RECV) && bus.res_in_sync;
  assign xfer     = rec_xfer || res_xfer;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sum_d = '0;
          if (len != '0) begin
            len_d   = len;
            load    = 1'b1;
            state_d = SEND;
          end else begin
            state_d = DONE;
          end
        end
      end
      SEND: begin
        if (rec_xfer) state_d = RECV;
      end
      RECV: begin
        if (res_xfer) begin
          sum_d   = sum_q + SUM_W'(bus.res_in);
          adv     = 1'b1;
          state_d = (idx + LEN_W'(1) < len_q) ? SEND : DONE;
        end
      end
      DONE: state_d = IDLE;
    endcase
    if (timeout) state_d = DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
    end
  end

`ifdef TF2_DRIVER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] stall_q, stall_d;
  logic          err_q, err_d;

  // counts consecutive busy cycles with no transfer on either port
  assign timeout = busy && !xfer &&
                   (stall_q + TW'(1) == TW'(TIMEOUT));

  always_comb begin
    stall_d = '0;
    err_d   = err_q;
    if (busy && !xfer) stall_d = stall_q + TW'(1);
    if (state_q == IDLE && start) err_d = 1'b0;
    if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign timeout        = 1'b0;
  assign err            = 1'b0;
`endif

  assign bus.rec_out        = rec;
  assign bus.rec_out_notify = (state_q == SEND);
  assign bus.res_in_notify  = (state_q == RECV);
  assign busy               = (state_q == SEND) || (state_q == RECV);
  assign done               = (state_q == DONE);
  assign sum                = sum_q;

endmodule

// File: tb/tb_tf2_record_driver.sv
// Scoreboard bench for tf2_record_driver (32-bit and 8-bit accumulator).
// Define TF2_DRIVER_TIMEOUT_EN to add the stall-timeout scenario.
module tb_tf2_record_driver;
  import testfunction2_types::*;

`ifdef TF2_DRIVER_TIMEOUT_EN
  localparam int TO = 5;
`else
  localparam int TO = 255;
`endif

  typedef struct {
    logic [31:0] s32;
    logic [7:0]  s8;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  len;
  logic [31:0] seed, stride;
  logic        busy, done, err;
  logic        busy8, done8, err8;
  logic [31:0] sum;
  logic [7:0]  sum8;

  tf2_record_driver_if bus ();
  tf2_record_driver_if bus8 ();

  assign bus8.rec_out_sync = bus.rec_out_sync;
  assign bus8.res_in_sync  = bus.res_in_sync;
  assign bus8.res_in       = bus.res_in;

  tf2_record_driver #(.LEN_W(8), .SUM_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .seed(seed), .stride(stride), .bus(bus),
    .busy(busy), .done(done), .sum(sum), .err(err)
  );

  tf2_record_driver #(.LEN_W(8), .SUM_W(8), .TIMEOUT(TO)) dut8 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .seed(seed), .stride(stride), .bus(bus8),
    .busy(busy8), .done(done8), .sum(sum8), .err(err8)
  );

  always #5 clk = ~clk;

  record_t     exp_rec[$];
  exp_t        exp_sum[$];
  logic [31:0] rep_q[$];
  logic [31:0] dir_rep[$];
  int          errors = 0;
  int          checks = 0;
  int          mode = 0;
  int          stall_left = 0;
  bit          pop_pend = 1'b0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got event want none", nm);
  endtask

  // reference: record i is (seed + i*stride, i); sum is plain total of replies
  task automatic prep(input int n, input logic [31:0] sd,
                      input logic [31:0] st);
    logic [31:0] tot, rv;
    exp_t        e;
    record_t     r;
    tot = 0;
    for (int i = 0; i < n; i++) begin
      r.x = sd + 32'(i) * st;
      r.y = 32'(i);
      exp_rec.push_back(r);
      if (dir_rep.size() > 0) rv = dir_rep.pop_front();
      else rv = $urandom;
      rep_q.push_back(rv);
      tot = tot + rv;
    end
    e.s32 = tot;
    e.s8  = tot[7:0];
    e.e   = 1'b0;
    exp_sum.push_back(e);
  endtask

  task automatic go(input int n, input logic [31:0] sd,
                    input logic [31:0] st, input bit poke,
                    output int k, output int bn, output int nn);
    len = 8'(n); seed = sd; stride = st; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; k = 1; bn = 0; nn = 0;
    while (!done && k < 400) begin
      if (busy) bn++;
      if (bus.rec_out_notify || bus.res_in_notify) nn++;
      start = poke && (k == 3);
      if (start) begin
        len = 8'd9; seed = $urandom; stride = $urandom;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    if (!done) fail("done_timeout");
    @(posedge clk); #1;
  endtask

  // consumer: presents replies in order, shapes sync per mode
  initial begin
    int lo;
    lo = 0;
    bus.rec_out_sync = 1'b1;
    bus.res_in_sync  = 1'b1;
    bus.res_in       = '0;
    forever begin
      @(posedge clk); #1;
      if (pop_pend) begin
        if (rep_q.size() > 0) rep_q.delete(0);
        pop_pend = 1'b0;
      end
      bus.res_in = (rep_q.size() > 0) ? rep_q[0] : '0;
      case (mode)
        1: begin
          bus.rec_out_sync = ($urandom_range(2) != 0) || lo >= 2;
          bus.res_in_sync  = ($urandom_range(2) != 0) || lo >= 2;
          lo = (bus.rec_out_sync && bus.res_in_sync) ? 0 : lo + 1;
        end
        2: begin
          bus.res_in_sync  = 1'b1;
          bus.rec_out_sync = 1'b1;
          if (bus.rec_out_notify && bus.rec_out.y == 32'd1 &&
              stall_left > 0) begin
            bus.rec_out_sync = 1'b0;
            stall_left--;
          end
        end
        3: begin
          bus.rec_out_sync = 1'b0;
          bus.res_in_sync  = 1'b1;
        end
        default: begin
          bus.rec_out_sync = 1'b1;
          bus.res_in_sync  = 1'b1;
        end
      endcase
    end
  end

  // monitor: pops expectations whenever the DUT transfers or finishes
  initial begin
    record_t r, prev_rec;
    exp_t    e;
    bit      prev_n, prev_x, rx;
    prev_n = 1'b0; prev_x = 1'b0; prev_rec = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_n = 1'b0;
        pop_pend = 1'b0;
        continue;
      end
      rx = bus.rec_out_notify && bus.rec_out_sync;
      if (prev_n && !prev_x && !done) begin
        check("hold_notify", 64'(bus.rec_out_notify), 64'd1);
        check("hold_rec", bus.rec_out, prev_rec);
      end
      check("excl_notify",
            64'(bus.rec_out_notify && bus.res_in_notify), 64'd0);
      if (rx) begin
        if (exp_rec.size() == 0) fail("unexpected_rec");
        else begin
          r = exp_rec.pop_front();
          check("rec", bus.rec_out, r);
        end
      end
      if (bus.res_in_notify && bus.res_in_sync) pop_pend = 1'b1;
      if (done) begin
        if (exp_sum.size() == 0) fail("unexpected_done");
        else begin
          e = exp_sum.pop_front();
          check("sum", 64'(sum), 64'(e.s32));
          check("sum8", 64'(sum8), 64'(e.s8));
          check("err", 64'(err), 64'(e.e));
          check("err8", 64'(err8), 64'(e.e));
          check("done8", 64'(done8), 64'd1);
          check("busy_at_done", 64'({busy, busy8}), 64'd0);
        end
      end
      prev_n = bus.rec_out_notify;
      prev_x = rx;
      prev_rec = bus.rec_out;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    int k, bn, nn, n;
    logic [31:0] sd, st;
    rst = 1'b1; start = 1'b0; len = '0; seed = '0; stride = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      check("idle_rec", bus.rec_out, 64'd0);
      check("idle_ctl", 64'({bus.rec_out_notify, bus.res_in_notify,
                             busy, done, err}), 64'd0);
      check("idle_sum", 64'(sum), 64'd0);
      @(posedge clk); #1;
    end

    dir_rep = {32'd5, 32'd7, 32'd9};
    prep(3, 32'd10, -32'sd4);
    go(3, 32'd10, -32'sd4, 1'b0, k, bn, nn);
    check("latency_len3", 64'(k), 64'd7);
    check("busy_cycles", 64'(bn), 64'd6);

    mode = 2; stall_left = 4;
    dir_rep = {32'd5, 32'd7, 32'd9};
    prep(3, 32'd10, -32'sd4);
    go(3, 32'd10, -32'sd4, 1'b0, k, bn, nn);
    check("latency_bp", 64'(k), 64'd11);
    mode = 0;

    prep(0, 32'd1, 32'd1);
    go(0, 32'd1, 32'd1, 1'b0, k, bn, nn);
    check("latency_len0", 64'(k), 64'd1);
    check("notify_len0", 64'(nn), 64'd0);

    dir_rep = {32'd200, 32'd100};
    prep(2, 32'd3, 32'd3);
    go(2, 32'd3, 32'd3, 1'b0, k, bn, nn);

    for (int b = 0; b < 14; b++) begin
      n = $urandom_range(0, 6);
      sd = $urandom; st = $urandom;
      mode = $urandom_range(0, 1);
      prep(n, sd, st);
      go(n, sd, st, (b % 3) == 0, k, bn, nn);
    end
    mode = 0;

    prep(4, 32'd100, 32'd1);
    len = 8'd4; seed = 32'd100; stride = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; k = 0;
    while (!bus.res_in_notify && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.res_in_notify) fail("recv_not_reached");
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_rec", bus.rec_out, 64'd0);
    check("rst_ctl", 64'({bus.rec_out_notify, bus.res_in_notify,
                          busy, done, err}), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    rst = 1'b0;
    exp_rec.delete(); exp_sum.delete(); rep_q.delete();
    pop_pend = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 64'({bus.rec_out_notify, busy, done}), 64'd0);

    prep(2, 32'd7, 32'd2);
    go(2, 32'd7, 32'd2, 1'b0, k, bn, nn);

`ifdef TF2_DRIVER_TIMEOUT_EN
    begin
      exp_t e;
      e.s32 = '0; e.s8 = '0; e.e = 1'b1;
      exp_sum.push_back(e);
      mode = 3;
      go(2, 32'd1, 32'd1, 1'b0, k, bn, nn);
      check("timeout_latency", 64'(k), 64'(TO + 1));
      check("err_sticky", 64'(err), 64'd1);
      mode = 0;
    end
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rec_queue_empty", 64'(exp_rec.size()), 64'd0);
    check("sum_queue_empty", 64'(exp_sum.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
